ras_ckpt_stack: RTL
===================

// Module: ras_ckpt_stack
// PURPOSE
// - Parametrised return-address stack (RAS) for the frontend branch predictor; generalises fixed-depth RAS.
// - Adds circular overwrite on overflow, saturating occupancy count, same-cycle push+pop (replace top),
//   flush, and a single checkpoint/restore for mispredict recovery.
// - Frontend drives push on call, pop on return; data_o/valid_o feed the return-target prediction mux.
// PARAMETERS
// - VLEN   default 32  width of stored return address
// - DEPTH  default 2   number of entries, >=1 (embedded cfg 2, application cfg 4/8)
// - PtrW   derived     DEPTH>1 ? $clog2(DEPTH) : 1
// - CntW   derived     $clog2(DEPTH+1)
// PORTS
// - clk_i         in   1     clock
// - rst_ni        in   1     asynchronous active-low reset
// - flush_i       in   1     empty the stack (frontend flush)
// - push_i        in   1     push data_i (call)
// - pop_i         in   1     pop top (return)
// - data_i        in   VLEN  return address to push
// - checkpoint_i  in   1     snapshot top pointer and count
// - restore_i     in   1     restore top pointer and count from snapshot
// - data_o        out  VLEN  current top entry, '0 when empty
// - valid_o       out  1     count_o != 0
// - count_o       out  CntW  occupancy, 0..DEPTH
// - overflow_o    out  1     1-cycle pulse: previous cycle's push overwrote oldest entry
// - underflow_o   out  1     1-cycle pulse: previous cycle's pop hit empty stack
// BEHAVIOUR
// - Reset: all entries, ptr, count, snapshot '0; overflow_o=0, underflow_o=0.
// - data_o = count==0 ? '0 : mem[ptr]; valid_o and count_o combinational from registers, no added latency.
// - Per-cycle priority: flush_i > restore_i > push/pop; checkpoint_i is independent of this priority.
// - flush_i: ptr<=0, count<=0, snapshot<=0; pushes, pops, restores and checkpoints that cycle are ignored.
// - restore_i (no flush): ptr<=snap_ptr, count<=snap_cnt; push/pop that cycle are ignored.
//   Entries are not restored: slots overwritten after the snapshot stay overwritten (accepted inaccuracy).
// - push only: ptr<=(ptr+1) mod DEPTH; mem[ptr+1 mod DEPTH]<=data_i; count<=min(count+1,DEPTH).
//   If count==DEPTH before the push, the oldest entry is lost and overflow_o=1 next cycle.
// - pop only, count>0: ptr<=(ptr-1) mod DEPTH; count<=count-1; mem unchanged.
// - pop only, count==0: state unchanged; underflow_o=1 next cycle.
// - push and pop, count>0: mem[ptr]<=data_i (top replaced); ptr and count unchanged; no pulses.
// - push and pop, count==0: behaves as push only (count becomes 1); no underflow.
// - checkpoint_i without flush: snap_ptr/snap_cnt <= ptr/count as they were before this cycle's update.
//   checkpoint_i together with restore_i: the restore completes and the snapshot takes the pre-restore state.
// - Pointer wrap: DEPTH need not be a power of two; increment/decrement wrap explicitly at DEPTH-1/0.
// - DEPTH==1: ptr stays 0; push always overwrites; a push while count==1 pulses overflow_o.
// - Reset asserted mid-operation clears everything asynchronously; the first cycle after release behaves as empty.
// TESTING (DEPTH=4, VLEN=32 unless noted)
// - Reset, no stimulus -> valid_o=0, count_o=0, data_o=0, overflow_o=0, underflow_o=0.
// - Push 0x100,0x200,0x300 -> data_o=0x300, count_o=3; pop -> data_o=0x200, count_o=2.
// - Push 0x10,0x20,0x30,0x40,0x50 -> overflow_o pulses once after 0x50, count_o=4;
//   4 pops return 0x50,0x40,0x30,0x20, then valid_o=0.
// - Pop on empty -> underflow_o=1 for exactly 1 cycle, count_o stays 0;
//   push+pop on empty with 0xAA -> count_o=1, data_o=0xAA.
// - Top=0x200 with count 2; push+pop with data_i=0x999 -> data_o=0x999, count_o=2.
// - Push 0x1,0x2; checkpoint; push 0x3,0x4; restore -> count_o=2, data_o=0x2;
//   flush together with restore -> count_o=0.
// - DEPTH=3 build: 4 pushes 0xA,0xB,0xC,0xD -> overflow_o pulses once, pops return 0xD,0xC,0xB.

Source files
------------

// File: rtl/ras_ckpt_stack.sv
// Return-address stack for the frontend predictor: circular overwrite on overflow,
// same-cycle replace-top, flush, and one checkpoint/restore slot for mispredict recovery.
module ras_ckpt_stack #(
  parameter int unsigned VLEN  = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [VLEN-1:0] data_i,
  input  logic            checkpoint_i,
  input  logic            restore_i,
  output logic [VLEN-1:0] data_o,
  output logic            valid_o,
  output logic [CntW-1:0] count_o,
  output logic            overflow_o,
  output logic            underflow_o
);

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_FLUSH,
    OP_RESTORE,
    OP_PUSH,
    OP_POP,
    OP_POP_EMPTY,
    OP_REPLACE
  } op_e;

  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [VLEN-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0] snap_ptr_q, snap_ptr_d;
  logic [CntW-1:0] snap_cnt_q, snap_cnt_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic            wr_en;
  logic [PtrW-1:0] wr_idx;
  logic [PtrW-1:0] ptr_inc, ptr_dec;
  logic            empty, full;
  op_e             op;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CntFull);

  // DEPTH need not be a power of two, so the pointer wraps explicitly at both ends.
  assign ptr_inc = (ptr_q == PtrLast) ? '0 : ptr_q + 1'b1;
  assign ptr_dec = (ptr_q == '0) ? PtrLast : ptr_q - 1'b1;

  always_comb begin
    op = OP_IDLE;
    if (flush_i) begin
      op = OP_FLUSH;
    end else if (restore_i) begin
      op = OP_RESTORE;
    end else if (push_i && pop_i && !empty) begin
      op = OP_REPLACE;
    end else if (push_i) begin
      op = OP_PUSH;
    end else if (pop_i) begin
      op = empty ? OP_POP_EMPTY : OP_POP;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    snap_ptr_d = snap_ptr_q;
    snap_cnt_d = snap_cnt_q;
    ovf_d      = 1'b0;
    unf_d      = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = ptr_q;

    unique case (op)
      OP_FLUSH: begin
        ptr_d = '0;
        cnt_d = '0;
      end
      OP_RESTORE: begin
        ptr_d = snap_ptr_q;
        cnt_d = snap_cnt_q;
      end
      OP_REPLACE: begin
        wr_en = 1'b1;
      end
      OP_PUSH: begin
        ptr_d  = ptr_inc;
        wr_en  = 1'b1;
        wr_idx = ptr_inc;
        ovf_d  = full;
        cnt_d  = full ? cnt_q : cnt_q + 1'b1;
      end
      OP_POP: begin
        ptr_d = ptr_dec;
        cnt_d = cnt_q - 1'b1;
      end
      OP_POP_EMPTY: begin
        unf_d = 1'b1;
      end
      default: ;
    endcase

    // Checkpoint sits outside the op priority: it captures the pre-update state,
    // even alongside a restore, but a flush clears the snapshot instead.
    if (flush_i) begin
      snap_ptr_d = '0;
      snap_cnt_d = '0;
    end else if (checkpoint_i) begin
      snap_ptr_d = ptr_q;
      snap_cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      cnt_q      <= '0;
      snap_ptr_q <= '0;
      snap_cnt_q <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the values from before this edge.
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      snap_ptr_q <= snap_ptr_d;
      snap_cnt_q <= snap_cnt_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // NOTE: the entry array is reset on purpose: a restore may expose a slot that
  // was never written since reset, and it must read as zero rather than X.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_idx] <= data_i;
    end
  end

  assign data_o      = empty ? '0 : mem_q[ptr_q];
  assign valid_o     = !empty;
  assign count_o     = cnt_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule
